// File: rtl/deserializer.sv
// deserializer
//   Collects a 1-bit serial stream, LSB first, into C_WIDTH-bit words.
//   Word alignment comes from hunting for SYNC_PATTERN. After lock, every
//   C_WIDTH valid bits form one word, which is queued in a small output FIFO
//   with a valid/ready handshake.
//
// Ports
//   clk_i           clock, at most one serial bit per cycle
//   rst_i           synchronous active-high reset
//   serial_i        serial data bit
//   serial_valid_i  serial_i is sampled only when high
//   align_req_i     one-cycle pulse: drop lock and re-hunt
//   data_o          head-of-FIFO word
//   valid_o         data_o valid
//   ready_i         consumer accepts data_o
//   locked_o        word alignment established
//   overflow_o      sticky: a word was dropped because the FIFO was full
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_HUNT   | searching the bit stream for SYNC_PATTERN, nothing is output
// S_LOCKED | aligned; every C_WIDTH valid bits are pushed as one word
module deserializer #(
  parameter int                 C_WIDTH      = 2,
  parameter logic [C_WIDTH-1:0] SYNC_PATTERN = 'b10,
  parameter int                 FIFO_DEPTH   = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               serial_i,
  input  logic               serial_valid_i,
  input  logic               align_req_i,
  output logic [C_WIDTH-1:0] data_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               locked_o,
  output logic               overflow_o
);

  localparam int CNT_W = (C_WIDTH > 2) ? $clog2(C_WIDTH) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {
    S_HUNT,
    S_LOCKED
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [C_WIDTH-1:0] window_q;
  logic               locked_q;

  logic [C_WIDTH-1:0] cand;
  logic               word_done;

  // The candidate is the window as it will look after this bit shifts in.
  assign cand = {serial_i, window_q[C_WIDTH-1:1]};

  // An align request wins over a word completing in the same cycle.
  assign word_done = (state_q == S_LOCKED) && serial_valid_i && !align_req_i &&
                     (bit_cnt_q == CNT_W'(C_WIDTH - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_HUNT;
      bit_cnt_q <= '0;
      window_q  <= '0;
      locked_q  <= 1'b0;
    end else begin
      // The window keeps shifting in every state, including during an align request.
      if (serial_valid_i) begin
        window_q <= cand;
      end
      if (align_req_i) begin
        state_q   <= S_HUNT;
        bit_cnt_q <= '0;
        locked_q  <= 1'b0;
      end else if (serial_valid_i) begin
        case (state_q)
          S_HUNT: begin
            if (cand == SYNC_PATTERN) begin
              state_q   <= S_LOCKED;
              bit_cnt_q <= '0;
              locked_q  <= 1'b1;
            end
          end
          S_LOCKED: begin
            if (word_done) begin
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q   <= S_HUNT;
            bit_cnt_q <= '0;
            locked_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Output FIFO
  logic [C_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               overflow_q, overflow_d;
  logic               pop, full, push_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign pop     = (occ_q != '0) && ready_i;
  assign full    = (occ_q == OCC_W'(FIFO_DEPTH));
  // A push into a full FIFO is still taken when the head leaves at the same edge.
  assign push_ok = word_done && (!full || pop);

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    occ_d      = occ_q;
    overflow_d = overflow_q;
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push_ok) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (push_ok && !pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (pop && !push_ok) begin
      occ_d = occ_q - OCC_W'(1);
    end
    if (word_done && !push_ok) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= cand;
      end
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      overflow_q <= overflow_d;
    end
  end

  assign data_o     = mem_q[rd_ptr_q];
  assign valid_o    = (occ_q != '0);
  assign locked_o   = locked_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_deserializer.sv
// Testbench for deserializer: directed scenarios followed by random traffic,
// all compared cycle by cycle against a queue-based reference model.
module tb_deserializer;

  localparam int              C_WIDTH    = 4;
  localparam logic [3:0]      SYNC       = 4'hA;
  localparam int              FIFO_DEPTH = 2;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b0;
  logic               serial_i = 1'b0;
  logic               serial_valid_i = 1'b0;
  logic               align_req_i = 1'b0;
  logic               ready_i = 1'b0;
  logic [C_WIDTH-1:0] data_o;
  logic               valid_o;
  logic               locked_o;
  logic               overflow_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit m_hist[$];
  bit m_cur[$];
  int m_fifo[$];
  bit m_locked;
  bit m_ovf;

  deserializer #(
    .C_WIDTH      (C_WIDTH),
    .SYNC_PATTERN (SYNC),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .serial_i       (serial_i),
    .serial_valid_i (serial_valid_i),
    .align_req_i    (align_req_i),
    .data_o         (data_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .locked_o       (locked_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_hist.delete();
    for (int i = 0; i < C_WIDTH; i++) m_hist.push_back(1'b0);
    m_cur.delete();
    m_fifo.delete();
    m_locked = 1'b0;
    m_ovf    = 1'b0;
  endtask

  function automatic int hist_val();
    int v = 0;
    foreach (m_hist[i]) v |= int'(m_hist[i]) << i;
    return v;
  endfunction

  // One clock edge worth of behaviour, from the observable rules:
  // last C_WIDTH bits give the sync candidate, words are built LSB first.
  task automatic m_edge(input bit v, input bit b, input bit al, input bit rd, input bit rs);
    int w;
    if (rs) begin
      m_reset();
      return;
    end
    if (rd && m_fifo.size() > 0) void'(m_fifo.pop_front());
    if (v) begin
      m_hist.push_back(b);
      void'(m_hist.pop_front());
    end
    if (al) begin
      m_locked = 1'b0;
      m_cur.delete();
    end else if (v) begin
      if (!m_locked) begin
        if (hist_val() == int'(SYNC)) begin
          m_locked = 1'b1;
          m_cur.delete();
        end
      end else begin
        m_cur.push_back(b);
        if (m_cur.size() == C_WIDTH) begin
          w = 0;
          foreach (m_cur[i]) w |= int'(m_cur[i]) << i;
          if (m_fifo.size() < FIFO_DEPTH) m_fifo.push_back(w);
          else m_ovf = 1'b1;
          m_cur.delete();
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("valid", 32'(valid_o), 32'(m_fifo.size() > 0));
    if (m_fifo.size() > 0) chk("data", 32'(data_o), 32'(m_fifo[0]));
    chk("locked", 32'(locked_o), 32'(m_locked));
    chk("overflow", 32'(overflow_o), 32'(m_ovf));
  endtask

  task automatic step(input bit v, input bit b, input bit al, input bit rd, input bit rs);
    @(negedge clk_i);
    serial_valid_i = v;
    serial_i       = b;
    align_req_i    = al;
    ready_i        = rd;
    rst_i          = rs;
    @(posedge clk_i);
    m_edge(v, b, al, rd, rs);
    #1;
    compare_all();
  endtask

  task automatic send_word(input logic [3:0] w, input bit rd);
    for (int i = 0; i < C_WIDTH; i++) step(1'b1, w[i], 1'b0, rd, 1'b0);
  endtask

  task automatic idle(input int n, input bit rd);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, rd, 1'b0);
  endtask

  initial begin
    logic [3:0] sw;
    sw = SYNC;
    m_reset();

    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_data", 32'(data_o), 32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);

    // Scenario 1: hunt, lock, two words with ready held high
    send_word(4'h0, 1'b1);
    send_word(sw, 1'b1);
    chk("s1_lock", 32'(locked_o), 32'h1);
    send_word(4'h3, 1'b1);
    chk("s1_w0", 32'(data_o), 32'h3);
    send_word(4'hE, 1'b1);
    chk("s1_w1", 32'(data_o), 32'hE);
    idle(2, 1'b1);

    // Scenario 2: gap of 3 invalid cycles mid-word
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("s2_w0", 32'(data_o), 32'h3);
    send_word(4'hE, 1'b1);
    idle(2, 1'b1);

    // Scenario 3: overflow with ready low, then drain
    send_word(4'h1, 1'b0);
    send_word(4'h2, 1'b0);
    send_word(4'h3, 1'b0);
    chk("s3_ovf", 32'(overflow_o), 32'h1);
    chk("s3_head", 32'(data_o), 32'h1);
    idle(4, 1'b1);

    // Scenario 4: align request two bits into a word
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("s4_unlock", 32'(locked_o), 32'h0);
    send_word(4'h0, 1'b1);
    send_word(sw, 1'b1);
    send_word(4'h5, 1'b1);
    chk("s4_w", 32'(data_o), 32'h5);
    idle(2, 1'b1);

    // Scenario 5: full FIFO, push and pop at the same edge
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_word(4'h0, 1'b0);
    send_word(sw, 1'b0);
    send_word(4'h7, 1'b0);
    send_word(4'h8, 1'b0);
    for (int i = 0; i < C_WIDTH - 1; i++) step(1'b1, i[0], 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("s5_noovf", 32'(overflow_o), 32'h0);
    idle(4, 1'b1);

    // Scenario 6: reset while locked with a word queued
    send_word(4'h9, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("s6_valid", 32'(valid_o), 32'h0);
    send_word(4'h0, 1'b1);
    send_word(sw, 1'b1);
    send_word(4'h3, 1'b1);
    chk("s6_w", 32'(data_o), 32'h3);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 39) == 0, $urandom_range(0, 4) > 1,
           $urandom_range(0, 199) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
